// File: rtl/panther_axi_wr_arbiter_if.sv
// Per-master and slave-side AXI write channels (AW, W, B) of panther_axi_wr_arbiter.
// The arbiter uses the slave modport; the requesting environment uses the master modport.
interface panther_axi_wr_arbiter_if #(
    parameter int NUM_MST        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_USER_WIDTH = 32
);
    localparam int IDX_W  = $clog2(NUM_MST);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int SID_W  = AXI_ID_WIDTH + IDX_W;

    logic [NUM_MST-1:0]                     s_aw_valid_i;
    logic [NUM_MST-1:0]                     s_aw_ready_o;
    logic [NUM_MST-1:0][AXI_ADDR_WIDTH-1:0] s_aw_addr_i;
    logic [NUM_MST-1:0][AXI_ID_WIDTH-1:0]   s_aw_id_i;
    logic [NUM_MST-1:0][7:0]                s_aw_len_i;
    logic [NUM_MST-1:0][2:0]                s_aw_size_i;
    logic [NUM_MST-1:0][1:0]                s_aw_burst_i;
    logic [NUM_MST-1:0][AXI_USER_WIDTH-1:0] s_aw_user_i;

    logic [NUM_MST-1:0]                     s_w_valid_i;
    logic [NUM_MST-1:0]                     s_w_ready_o;
    logic [NUM_MST-1:0][AXI_DATA_WIDTH-1:0] s_w_data_i;
    logic [NUM_MST-1:0][STRB_W-1:0]         s_w_strb_i;
    logic [NUM_MST-1:0]                     s_w_last_i;
    logic [NUM_MST-1:0][AXI_USER_WIDTH-1:0] s_w_user_i;

    logic [NUM_MST-1:0]                     s_b_valid_o;
    logic [NUM_MST-1:0]                     s_b_ready_i;
    logic [NUM_MST-1:0][AXI_ID_WIDTH-1:0]   s_b_id_o;
    logic [NUM_MST-1:0][1:0]                s_b_resp_o;
    logic [NUM_MST-1:0][AXI_USER_WIDTH-1:0] s_b_user_o;

    logic                      m_aw_valid_o;
    logic                      m_aw_ready_i;
    logic [AXI_ADDR_WIDTH-1:0] m_aw_addr_o;
    logic [SID_W-1:0]          m_aw_id_o;
    logic [7:0]                m_aw_len_o;
    logic [2:0]                m_aw_size_o;
    logic [1:0]                m_aw_burst_o;
    logic [AXI_USER_WIDTH-1:0] m_aw_user_o;

    logic                      m_w_valid_o;
    logic                      m_w_ready_i;
    logic [AXI_DATA_WIDTH-1:0] m_w_data_o;
    logic [STRB_W-1:0]         m_w_strb_o;
    logic                      m_w_last_o;
    logic [AXI_USER_WIDTH-1:0] m_w_user_o;

    logic                      m_b_valid_i;
    logic                      m_b_ready_o;
    logic [SID_W-1:0]          m_b_id_i;
    logic [1:0]                m_b_resp_i;
    logic [AXI_USER_WIDTH-1:0] m_b_user_i;

    modport slave (
        input  s_aw_valid_i, s_aw_addr_i, s_aw_id_i, s_aw_len_i, s_aw_size_i, s_aw_burst_i, s_aw_user_i,
        output s_aw_ready_o,
        input  s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i, s_w_user_i,
        output s_w_ready_o,
        output s_b_valid_o, s_b_id_o, s_b_resp_o, s_b_user_o,
        input  s_b_ready_i,
        output m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o, m_aw_user_o,
        input  m_aw_ready_i,
        output m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o, m_w_user_o,
        input  m_w_ready_i,
        input  m_b_valid_i, m_b_id_i, m_b_resp_i, m_b_user_i,
        output m_b_ready_o
    );

    modport master (
        output s_aw_valid_i, s_aw_addr_i, s_aw_id_i, s_aw_len_i, s_aw_size_i, s_aw_burst_i, s_aw_user_i,
        input  s_aw_ready_o,
        output s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i, s_w_user_i,
        input  s_w_ready_o,
        input  s_b_valid_o, s_b_id_o, s_b_resp_o, s_b_user_o,
        output s_b_ready_i,
        input  m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o, m_aw_user_o,
        output m_aw_ready_i,
        input  m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o, m_w_user_o,
        output m_w_ready_i,
        output m_b_valid_i, m_b_id_i, m_b_resp_i, m_b_user_i,
        input  m_b_ready_o
    );
endinterface

// File: rtl/panther_axi_wr_arbiter.sv
// AXI write arbiter: one registered AW grant at a time with the winner index prefixed onto the ID,
// a grant-order FIFO steering W beats, and B routed back by the ID prefix.
// Define PANTHER_AXI_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module panther_axi_wr_arbiter #(
    parameter int NUM_MST        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_USER_WIDTH = 32,
    parameter int W_FIFO_DEPTH   = 4
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    panther_axi_wr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MST);
    localparam int FA_W  = $clog2(W_FIFO_DEPTH);
    localparam int PTR_W = FA_W + 1;
    localparam int SID_W = AXI_ID_WIDTH + IDX_W;

    typedef enum logic {ST_IDLE, ST_HOLD} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          start_idx, win_idx, head;
    logic                      win_found, grant, push, pop;
    logic                      fifo_full, fifo_empty;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0]          fifo_mem [W_FIFO_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [SID_W-1:0]          aw_id_q;
    logic [7:0]                aw_len_q;
    logic [2:0]                aw_size_q;
    logic [1:0]                aw_burst_q;
    logic [AXI_USER_WIDTH-1:0] aw_user_q;
    logic [IDX_W-1:0]          b_sel;
    logic                      b_sel_ok;

`ifdef PANTHER_AXI_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    // The pointer only advances once the slave has actually taken the AW.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (push) begin
            rr_ptr_q <= (idx_q == IDX_W'(NUM_MST - 1)) ? '0 : idx_q + 1'b1;
        end
    end
    assign start_idx = rr_ptr_q;
`endif

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            cand = (int'(start_idx) + i) % NUM_MST;
            if (!win_found && bus.s_aw_valid_i[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Full is judged on registered pointers, so a same-cycle pop does not help.
                if (rst_ni && win_found && !fifo_full) begin
                    grant   = 1'b1;
                    idx_d   = win_idx;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.m_aw_ready_i) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.s_aw_ready_o = '0;
        if (grant) bus.s_aw_ready_o[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_user_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (grant) begin
                aw_addr_q  <= bus.s_aw_addr_i[win_idx];
                aw_id_q    <= {win_idx, bus.s_aw_id_i[win_idx]};
                aw_len_q   <= bus.s_aw_len_i[win_idx];
                aw_size_q  <= bus.s_aw_size_i[win_idx];
                aw_burst_q <= bus.s_aw_burst_i[win_idx];
                aw_user_q  <= bus.s_aw_user_i[win_idx];
            end
        end
    end

    assign bus.m_aw_valid_o = (state_q == ST_HOLD);
    assign bus.m_aw_addr_o  = aw_addr_q;
    assign bus.m_aw_id_o    = aw_id_q;
    assign bus.m_aw_len_o   = aw_len_q;
    assign bus.m_aw_size_o  = aw_size_q;
    assign bus.m_aw_burst_o = aw_burst_q;
    assign bus.m_aw_user_o  = aw_user_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FA_W] != rd_ptr_q[FA_W]) &&
                        (wr_ptr_q[FA_W-1:0] == rd_ptr_q[FA_W-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q[FA_W-1:0]] <= idx_q;
    end

    assign head = fifo_mem[rd_ptr_q[FA_W-1:0]];

    assign bus.m_w_valid_o = !fifo_empty && bus.s_w_valid_i[head];
    assign bus.m_w_data_o  = bus.s_w_data_i[head];
    assign bus.m_w_strb_o  = bus.s_w_strb_i[head];
    assign bus.m_w_last_o  = bus.s_w_last_i[head];
    assign bus.m_w_user_o  = bus.s_w_user_i[head];
    assign pop             = bus.m_w_valid_o && bus.m_w_ready_i && bus.m_w_last_o;

    always_comb begin
        bus.s_w_ready_o = '0;
        if (!fifo_empty) bus.s_w_ready_o[head] = bus.m_w_ready_i;
    end

    // Unreachable prefixes (non power-of-2 NUM_MST) are swallowed so the slave never stalls.
    assign b_sel    = bus.m_b_id_i[SID_W-1 -: IDX_W];
    assign b_sel_ok = (int'(b_sel) < NUM_MST);

    always_comb begin
        bus.s_b_valid_o = '0;
        bus.m_b_ready_o = 1'b1;
        if (b_sel_ok) begin
            bus.s_b_valid_o[b_sel] = bus.m_b_valid_i;
            bus.m_b_ready_o        = bus.s_b_ready_i[b_sel];
        end
    end

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_b_fanout
        assign bus.s_b_id_o[gi]   = bus.m_b_id_i[AXI_ID_WIDTH-1:0];
        assign bus.s_b_resp_o[gi] = bus.m_b_resp_i;
        assign bus.s_b_user_o[gi] = bus.m_b_user_i;
    end
endmodule

// File: tb/tb_panther_axi_wr_arbiter.sv
// Directed bench for panther_axi_wr_arbiter: AW grant order, FIFO gating, W ordering, B routing, reset.
module tb_panther_axi_wr_arbiter;
    localparam int NUM_MST = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int IW      = 8;
    localparam int UW      = 32;
    localparam int IDX_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    panther_axi_wr_arbiter_if #(
        .NUM_MST(NUM_MST), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
    ) bus ();

    panther_axi_wr_arbiter #(
        .NUM_MST(NUM_MST), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW), .W_FIFO_DEPTH(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed 0x%0h", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_aw_valid_i = '0;
        bus.s_aw_addr_i  = '0;
        bus.s_aw_id_i    = '0;
        bus.s_aw_len_i   = '0;
        bus.s_aw_size_i  = '0;
        bus.s_aw_burst_i = '0;
        bus.s_aw_user_i  = '0;
        bus.s_w_valid_i  = '0;
        bus.s_w_data_i   = '0;
        bus.s_w_strb_i   = '0;
        bus.s_w_last_i   = '0;
        bus.s_w_user_i   = '0;
        bus.s_b_ready_i  = '0;
        bus.m_aw_ready_i = 1'b0;
        bus.m_w_ready_i  = 1'b0;
        bus.m_b_valid_i  = 1'b0;
        bus.m_b_id_i     = '0;
        bus.m_b_resp_i   = '0;
        bus.m_b_user_i   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [IDX_W-1:0] rr_exp [5];
        logic [IDX_W-1:0] drain_exp [4];
        int grants;
`ifdef PANTHER_AXI_ARB_FIXED_PRIO_EN
        rr_exp    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        drain_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        rr_exp    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        drain_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
`endif
        // Reset state
        clear_inputs();
        tick();
        tick();
        check("rst_m_aw_valid", bus.m_aw_valid_o, 0);
        check("rst_s_aw_ready", bus.s_aw_ready_o, 0);
        check("rst_m_w_valid", bus.m_w_valid_o, 0);
        check("rst_s_w_ready", bus.s_w_ready_o, 0);
        check("rst_m_aw_id", bus.m_aw_id_o, 0);
        check("rst_m_aw_addr", bus.m_aw_addr_o, 0);
        check("rst_s_b_valid", bus.s_b_valid_o, 0);
        check("rst_m_b_ready", bus.m_b_ready_o, 0);
        rst_n = 1'b1;

        // Single master: master 2, id 0x05, len 3
        bus.s_aw_valid_i    = 4'b0100;
        bus.s_aw_addr_i[2]  = 32'h1000_0040;
        bus.s_aw_id_i[2]    = 8'h05;
        bus.s_aw_len_i[2]   = 8'd3;
        bus.s_aw_size_i[2]  = 3'd2;
        bus.s_aw_burst_i[2] = 2'b01;
        bus.s_aw_user_i[2]  = 32'hCAFE_0002;
        #1;
        check("t1_aw_ready_pulse", bus.s_aw_ready_o, 4'b0100);
        check("t1_m_aw_valid_pre", bus.m_aw_valid_o, 0);
        tick();
        check("t1_aw_ready_hold", bus.s_aw_ready_o, 0);
        bus.s_aw_valid_i = '0;
        check("t1_m_aw_valid", bus.m_aw_valid_o, 1);
        check("t1_m_aw_id", bus.m_aw_id_o, 10'h205);
        check("t1_m_aw_addr", bus.m_aw_addr_o, 32'h1000_0040);
        check("t1_m_aw_len", bus.m_aw_len_o, 8'd3);
        check("t1_m_aw_size_burst", {bus.m_aw_size_o, bus.m_aw_burst_o}, 5'b010_01);
        check("t1_m_aw_user", bus.m_aw_user_o, 32'hCAFE_0002);
        bus.m_aw_ready_i = 1'b1;
        tick();
        bus.m_aw_ready_i = 1'b0;
        check("t1_m_aw_valid_done", bus.m_aw_valid_o, 0);
        bus.m_w_ready_i   = 1'b1;
        bus.s_w_valid_i   = 4'b0100;
        bus.s_w_strb_i[2] = 4'hF;
        for (int b = 0; b < 4; b++) begin
            bus.s_w_data_i[2] = 32'hD000_0000 + b;
            bus.s_w_last_i[2] = (b == 3);
            #1;
            check("t1_w_ready", bus.s_w_ready_o, 4'b0100);
            check("t1_w_data", bus.m_w_data_o, 32'hD000_0000 + b);
            check("t1_w_last", bus.m_w_last_o, (b == 3));
            tick();
        end
        bus.s_w_last_i[2] = 1'b0;
        #1;
        check("t1_w_popped_valid", bus.m_w_valid_o, 0);
        check("t1_w_popped_ready", bus.s_w_ready_o, 0);
        clear_inputs();
        bus.m_b_valid_i = 1'b1;
        bus.m_b_id_i    = 10'h205;
        bus.m_b_resp_i  = 2'b01;
        bus.s_b_ready_i = 4'b0100;
        #1;
        check("t1_b_valid", bus.s_b_valid_o, 4'b0100);
        check("t1_b_id", bus.s_b_id_o[2], 8'h05);
        check("t1_b_resp", bus.s_b_resp_o[2], 2'b01);
        check("t1_b_ready", bus.m_b_ready_o, 1);
        tick();

        // Round robin with all four masters requesting
        do_reset();
        for (int m = 0; m < NUM_MST; m++) bus.s_aw_id_i[m] = 8'(17 * m);
        bus.s_aw_valid_i = 4'b1111;
        bus.m_aw_ready_i = 1'b1;
        bus.s_w_valid_i  = 4'b1111;
        bus.s_w_last_i   = 4'b1111;
        bus.m_w_ready_i  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check("rr_grant", bus.s_aw_ready_o, 4'b0001 << rr_exp[g]);
            tick();
            check("rr_m_aw_id", bus.m_aw_id_o, {rr_exp[g], 8'(17 * rr_exp[g])});
            tick();
        end

        // FIFO full: no W accepted, count AW handshakes
        do_reset();
        bus.s_aw_valid_i = 4'b1111;
        bus.m_aw_ready_i = 1'b1;
        bus.s_w_valid_i  = 4'b1111;
        bus.s_w_last_i   = 4'b1111;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            grants += $countones(bus.s_aw_ready_o);
            tick();
        end
        check("full_aw_handshakes", grants, 4);
        #1;
        check("full_no_grant", bus.s_aw_ready_o, 0);
        check("full_m_aw_idle", bus.m_aw_valid_o, 0);
        bus.m_w_ready_i = 1'b1;
        #1;
        check("full_pop_cycle_grant", bus.s_aw_ready_o, 0);
        check("full_w_head", bus.s_w_ready_o, 4'b0001);
        tick();
        bus.m_w_ready_i = 1'b0;
        #1;
        check("full_5th_grant", bus.s_aw_ready_o, 4'b0001);
        tick();
        tick();
        bus.s_aw_valid_i = '0;
        bus.m_aw_ready_i = 1'b0;
        bus.m_w_ready_i  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("full_drain_order", bus.s_w_ready_o, 4'b0001 << drain_exp[j]);
            tick();
        end
        #1;
        check("full_drain_empty", bus.s_w_ready_o, 0);

        // W ordering: grant master 1 then master 3, master 3 presents W first
        do_reset();
        bus.s_aw_valid_i = 4'b1010;
        bus.m_aw_ready_i = 1'b1;
        #1;
        check("wo_grant_m1", bus.s_aw_ready_o, 4'b0010);
        tick();
        bus.s_aw_valid_i[1] = 1'b0;
        tick();
        #1;
        check("wo_grant_m3", bus.s_aw_ready_o, 4'b1000);
        tick();
        bus.s_aw_valid_i = '0;
        tick();
        bus.m_aw_ready_i  = 1'b0;
        bus.m_w_ready_i   = 1'b1;
        bus.s_w_valid_i   = 4'b1000;
        bus.s_w_last_i    = 4'b1000;
        bus.s_w_data_i[3] = 32'h3333_0000;
        #1;
        check("wo_m3_blocked", bus.s_w_ready_o, 4'b0010);
        check("wo_m_w_valid_wait", bus.m_w_valid_o, 0);
        tick();
        bus.s_w_valid_i   = 4'b1010;
        bus.s_w_data_i[1] = 32'h1111_0000;
        #1;
        check("wo_m1_beat1_data", bus.m_w_data_o, 32'h1111_0000);
        check("wo_m1_beat1_ready", bus.s_w_ready_o, 4'b0010);
        tick();
        bus.s_w_data_i[1] = 32'h1111_0001;
        bus.s_w_last_i    = 4'b1010;
        #1;
        check("wo_m1_last_ready", bus.s_w_ready_o, 4'b0010);
        check("wo_m1_last", bus.m_w_last_o, 1);
        tick();
        bus.s_w_valid_i = 4'b1000;
        #1;
        check("wo_m3_now_ready", bus.s_w_ready_o, 4'b1000);
        check("wo_m3_data", bus.m_w_data_o, 32'h3333_0000);
        tick();
        #1;
        check("wo_fifo_empty", bus.s_w_ready_o, 0);

        // Interleaved B
        clear_inputs();
        bus.m_b_valid_i = 1'b1;
        bus.m_b_id_i    = 10'h1AA;
        bus.s_b_ready_i = 4'b0010;
        #1;
        check("b_aa_valid", bus.s_b_valid_o, 4'b0010);
        check("b_aa_id", bus.s_b_id_o[1], 8'hAA);
        check("b_aa_ready", bus.m_b_ready_o, 1);
        bus.s_b_ready_i = 4'b0001;
        #1;
        check("b_aa_not_ready", bus.m_b_ready_o, 0);
        tick();
        bus.m_b_id_i   = 10'h0BB;
        bus.m_b_resp_i = 2'b10;
        #1;
        check("b_bb_valid", bus.s_b_valid_o, 4'b0001);
        check("b_bb_id", bus.s_b_id_o[0], 8'hBB);
        check("b_bb_resp", bus.s_b_resp_o[0], 2'b10);
        check("b_bb_ready", bus.m_b_ready_o, 1);
        tick();
        clear_inputs();

        // Reset during beat 2 of a len=7 burst from master 2
        bus.s_aw_valid_i   = 4'b0100;
        bus.s_aw_id_i[2]   = 8'h42;
        bus.s_aw_len_i[2]  = 8'd7;
        tick();
        bus.s_aw_valid_i = '0;
        bus.m_aw_ready_i = 1'b1;
        tick();
        bus.m_aw_ready_i = 1'b0;
        bus.m_w_ready_i  = 1'b1;
        bus.s_w_valid_i  = 4'b0100;
        tick();
        #1;
        check("rm_beat2_on_bus", bus.m_w_valid_o, 1);
        rst_n = 1'b0;
        tick();
        check("rm_m_w_valid", bus.m_w_valid_o, 0);
        check("rm_s_w_ready", bus.s_w_ready_o, 0);
        check("rm_m_aw_valid", bus.m_aw_valid_o, 0);
        check("rm_m_aw_id", bus.m_aw_id_o, 0);
        rst_n = 1'b1;
        bus.s_aw_valid_i = 4'b1010;
        #1;
        check("rm_rr_ptr_reset", bus.s_aw_ready_o, 4'b0010);
        tick();
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/panther_axi_wr_arbiter.md
# panther_axi_wr_arbiter

Round-robin arbiter that shares the cluster's single AXI data slave write path (AW, W, B) between `NUM_MST` requesting masters. It registers one address-write grant at a time and prefixes the winner's index onto the AXI ID. It records grant order in a small FIFO so W beats follow AW order, and routes B responses back by the ID prefix. It sits between the cluster-side write requesters and the `sv_axi_interface` data slave port driven by the acceptance environment.

## Interface
- `NUM_MST`, 4: number of requesting masters, 2..8.
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 32: data width; strobe is `AXI_DATA_WIDTH/8`.
- `AXI_ID_WIDTH`, 8: master-side ID width. Slave-side ID width is `AXI_ID_WIDTH + IDX_W`, with `IDX_W = $clog2(NUM_MST)`.
- `AXI_USER_WIDTH`, 32: user width, passed through unchanged.
- `W_FIFO_DEPTH`, 4: grant-order FIFO depth, which is the maximum number of AW accepted ahead of their W bursts (power of 2).
- `clk_i` in 1: clock, all logic rising-edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `s_aw_valid_i`/`s_aw_ready_o` in/out `[NUM_MST]`: per-master AW handshake.
- `s_aw_addr_i`, `s_aw_id_i`, `s_aw_len_i`(8), `s_aw_size_i`(3), `s_aw_burst_i`(2), `s_aw_user_i` in, packed `[NUM_MST]`: AW payloads.
- `s_w_valid_i`/`s_w_ready_o`, `s_w_data_i`, `s_w_strb_i`, `s_w_last_i`, `s_w_user_i`: per-master W channel.
- `s_b_valid_o`/`s_b_ready_i`, `s_b_id_o`(`AXI_ID_WIDTH`), `s_b_resp_o`(2), `s_b_user_o`: per-master B channel.
- `m_aw_*` out (ready in): slave-side AW, with ID `AXI_ID_WIDTH+IDX_W` bits.
- `m_w_*` out (ready in): slave-side W.
- `m_b_*` in (ready out): slave-side B.

## Operation
- **AW state machine, IDLE/HOLD.**
  - IDLE: if any `s_aw_valid_i` is set and the FIFO is not full, pick a winner starting the search at `rr_ptr`. Register its payload and set `m_aw_id_o = {idx, s_aw_id}`. Pulse `s_aw_ready_o[idx]` in the same cycle. Go to HOLD.
  - HOLD: `m_aw_valid_o=1` with a stable payload. On `m_aw_ready_i`, push `idx` into the FIFO, set `rr_ptr = idx+1` (mod `NUM_MST`) and return to IDLE.
- **Grant gating.** No grant is issued while the FIFO is full. A pop in the same cycle does not free a slot for that cycle's grant decision.
- **W routing.** When the FIFO is non-empty, the head `h` selects the master:
  - `m_w_* = s_w_*[h]` and `s_w_ready_o[h] = m_w_ready_i`.
  - All other `s_w_ready_o` are 0.
  - A handshake with `w_last=1` pops the FIFO.
  - When the FIFO is empty, `m_w_valid_o=0` and all `s_w_ready_o=0`.
- **B routing.** This path is combinational and stateless.
  - `k = m_b_id_i[top IDX_W bits]`.
  - `s_b_valid_o[k] = m_b_valid_i`, `s_b_id_o[k]` is the lower ID bits, and `m_b_ready_o = s_b_ready_i[k]`.
  - An out-of-range `k` is not possible when `NUM_MST` is a power of 2; otherwise it is accepted and dropped with `m_b_ready_o=1`.
- **Arithmetic.** `rr_ptr` is `IDX_W` bits with modulo-`NUM_MST` wrap. FIFO pointers are `log2(W_FIFO_DEPTH)+1` bits; full means the MSBs differ and the rest are equal.

## Timing
- **Reset values.** All `*_valid_o` and `*_ready_o` are 0, state is IDLE, `rr_ptr=0`, FIFO is empty, and registered AW payload outputs are 0.
- **AW latency.** `s_aw_valid` sampled in cycle N gives `m_aw_valid_o` in N+1. The minimum AW repeat interval is 2 cycles.
- **W path.** W is combinational through the mux, so the earliest W beat is accepted one cycle after the corresponding AW handshake.
- **B path.** B is combinational, with zero latency.
- **Reset mid-burst.** A reset during a burst discards the FIFO and any held AW. Partially forwarded bursts are not completed.
- **Simultaneous push and pop.** A push and pop in the same cycle (FIFO not full) leaves the count unchanged.

## Configuration
- `PANTHER_AXI_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, with the lowest index winning. `rr_ptr` is removed and the search always starts at 0.
  - Undefined (default): round-robin as above.

## Test plan
- **Single master.** Master 2 issues AW id=0x05, len=3, then 4 W beats. Expect `m_aw_id_o={2'b10,8'h05}` one cycle later, 4 W beats forwarded with last on beat 4, and a B with id `0x205` delivered to master 2 with id 0x05.
- **Round robin.** Masters 0–3 assert AW continuously. Expect grants 0,1,2,3,0 in order. With the macro defined, expect 0,0,0 for as long as master 0 requests.
- **FIFO full.** Hold `m_w_ready_i=0` while 5 AW requests are pending. Expect exactly 4 AW handshakes and no 5th grant until the first `w_last` pop, after which the 5th AW is issued.
- **W ordering.** Grant master 1 then master 3; master 3 asserts W first. Expect `s_w_ready_o[3]=0` until master 1's last beat completes.
- **Interleaved B.** Out-of-order B ids `0x1AA` then `0x0BB`. Expect master 1 to receive `0xAA` and master 0 to receive `0xBB`, with `m_b_ready_o` following the selected master's ready.
- **Reset mid-operation.** Assert `rst_ni=0` during beat 2 of a len=7 burst. Expect all outputs 0 on the next edge, an empty FIFO, and `rr_ptr=0`.
